// File: rtl/fc_layer.sv
// rtl/fc_layer.sv - fully connected layer: 8 pooled 12x12 maps into 10 class scores via a streamed weight ROM.
module fc_layer #(
    parameter int DATA_W   = 69,
    parameter int MAPS     = 8,
    parameter int POOL_X   = 12,
    parameter int POOL_Y   = 12,
    parameter int CLASSES  = 10,
    parameter int WEIGHT_W = 16,
    parameter int ACC_W    = 98,
    parameter int ADDR_W   = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fc_enable,
    input  logic                    pool_done,
    input  logic [DATA_W-1:0]       pool_result_1 [POOL_X][POOL_Y],
    input  logic [DATA_W-1:0]       pool_result_2 [POOL_X][POOL_Y],
    input  logic [DATA_W-1:0]       pool_result_3 [POOL_X][POOL_Y],
    input  logic [DATA_W-1:0]       pool_result_4 [POOL_X][POOL_Y],
    input  logic [DATA_W-1:0]       pool_result_5 [POOL_X][POOL_Y],
    input  logic [DATA_W-1:0]       pool_result_6 [POOL_X][POOL_Y],
    input  logic [DATA_W-1:0]       pool_result_7 [POOL_X][POOL_Y],
    input  logic [DATA_W-1:0]       pool_result_8 [POOL_X][POOL_Y],
    output logic [ADDR_W-1:0]       weight_addr,
    output logic                    weight_rd_en,
    input  logic [WEIGHT_W-1:0]     weight_data,
    output logic signed [ACC_W-1:0] fc_result [CLASSES],
    output logic                    fc_done
);

    localparam int LAST   = CLASSES * MAPS * POOL_X * POOL_Y - 1;
    localparam int PROD_W = DATA_W + 1 + WEIGHT_W;
    localparam int YW     = $clog2(POOL_Y);
    localparam int XW     = $clog2(POOL_X);
    localparam int MW     = $clog2(MAPS);
    localparam int CW     = $clog2(CLASSES + 1);

    typedef enum logic [1:0] {IDLE, MAC, DRAIN, DONE} state_t;

    state_t state, state_next;
    logic start, abort, load_result;

    logic [ADDR_W-1:0] addr;
    logic [YW-1:0]     cnt_y;
    logic [XW-1:0]     cnt_x;
    logic [MW-1:0]     cnt_map;
    logic [CW-1:0]     cnt_cls;
    logic              drain_cnt;

    logic [DATA_W-1:0]       buffer [MAPS][POOL_X][POOL_Y];
    logic signed [ACC_W-1:0] acc [CLASSES];

    logic              pipe_valid;
    logic [DATA_W-1:0] pipe_pixel;
    logic [CW-1:0]     pipe_cls;

    logic signed [PROD_W-1:0] pixel_ext, weight_ext, product;
    logic signed [ACC_W-1:0]  product_ext;

    always_comb begin
        state_next   = state;
        start        = 1'b0;
        abort        = 1'b0;
        load_result  = 1'b0;
        weight_rd_en = 1'b0;
        weight_addr  = '0;
        case (state)
            IDLE: begin
                if (fc_enable && pool_done) begin
                    state_next = MAC;
                    start      = 1'b1;
                end
            end
            MAC: begin
                weight_rd_en = 1'b1;
                weight_addr  = addr;
                if (!fc_enable) begin
                    state_next = IDLE;
                    abort      = 1'b1;
                end else if (addr == ADDR_W'(LAST)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!fc_enable) begin
                    state_next = IDLE;
                    abort      = 1'b1;
                end else if (drain_cnt) begin
                    state_next  = DONE;
                    load_result = 1'b1;
                end
            end
            DONE: begin
                if (!fc_enable) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Pixel is unsigned: zero-extend before the signed multiply.
    assign pixel_ext   = {{(PROD_W-DATA_W){1'b0}}, pipe_pixel};
    assign weight_ext  = {{(PROD_W-WEIGHT_W){weight_data[WEIGHT_W-1]}}, weight_data};
    assign product     = pixel_ext * weight_ext;
    assign product_ext = {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr       <= '0;
            cnt_y      <= '0;
            cnt_x      <= '0;
            cnt_map    <= '0;
            cnt_cls    <= '0;
            drain_cnt  <= 1'b0;
            pipe_valid <= 1'b0;
            fc_done    <= 1'b0;
            for (int i = 0; i < CLASSES; i++) begin
                acc[i]       <= '0;
                fc_result[i] <= '0;
            end
        end else begin
            state      <= state_next;
            fc_done    <= (state_next == DONE);
            // Tag stage lines up with the ROM's one-cycle read latency.
            pipe_valid <= weight_rd_en && !abort;
            drain_cnt  <= (state == DRAIN) ? ~drain_cnt : 1'b0;

            if (start) begin
                addr    <= '0;
                cnt_y   <= '0;
                cnt_x   <= '0;
                cnt_map <= '0;
                cnt_cls <= '0;
            end else if (state == MAC) begin
                addr <= addr + ADDR_W'(1);
                if (cnt_y == YW'(POOL_Y - 1)) begin
                    cnt_y <= '0;
                    if (cnt_x == XW'(POOL_X - 1)) begin
                        cnt_x <= '0;
                        if (cnt_map == MW'(MAPS - 1)) begin
                            cnt_map <= '0;
                            cnt_cls <= cnt_cls + CW'(1);
                        end else begin
                            cnt_map <= cnt_map + MW'(1);
                        end
                    end else begin
                        cnt_x <= cnt_x + XW'(1);
                    end
                end else begin
                    cnt_y <= cnt_y + YW'(1);
                end
            end

            if (start) begin
                for (int i = 0; i < CLASSES; i++) acc[i] <= '0;
            end else if (pipe_valid && !abort) begin
                acc[pipe_cls] <= acc[pipe_cls] + product_ext;
            end

            if (load_result) begin
                fc_result <= acc;
            end else if (abort) begin
                for (int i = 0; i < CLASSES; i++) fc_result[i] <= '0;
            end
        end
    end

    // Snapshot and pixel tag carry no reset; both are reloaded before use.
    always_ff @(posedge clk) begin
        if (start) begin
            buffer[0] <= pool_result_1;
            buffer[1] <= pool_result_2;
            buffer[2] <= pool_result_3;
            buffer[3] <= pool_result_4;
            buffer[4] <= pool_result_5;
            buffer[5] <= pool_result_6;
            buffer[6] <= pool_result_7;
            buffer[7] <= pool_result_8;
        end
        pipe_pixel <= buffer[cnt_map][cnt_x][cnt_y];
        pipe_cls   <= cnt_cls;
    end

endmodule

// File: tb/tb_fc_layer.sv
// tb/tb_fc_layer.sv - scoreboard bench for fc_layer with directed pixel/weight patterns.
module tb_fc_layer;

    localparam int RUN_LEN = 11522;

    logic clk = 1'b0;
    logic rst, fc_enable, pool_done;
    logic [68:0] p1 [12][12], p2 [12][12], p3 [12][12], p4 [12][12];
    logic [68:0] p5 [12][12], p6 [12][12], p7 [12][12], p8 [12][12];
    logic [13:0] weight_addr;
    logic        weight_rd_en;
    logic [15:0] weight_data = 16'd0;
    logic signed [97:0] fc_result [10];
    logic        fc_done;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int rom_mode = 0;
    logic done_prev = 1'b0;

    typedef struct packed {
        logic [31:0]       done_cyc;
        logic [9:0][97:0]  res;
    } exp_t;
    exp_t sb [$];

    fc_layer dut (
        .clk(clk), .rst(rst), .fc_enable(fc_enable), .pool_done(pool_done),
        .pool_result_1(p1), .pool_result_2(p2), .pool_result_3(p3), .pool_result_4(p4),
        .pool_result_5(p5), .pool_result_6(p6), .pool_result_7(p7), .pool_result_8(p8),
        .weight_addr(weight_addr), .weight_rd_en(weight_rd_en), .weight_data(weight_data),
        .fc_result(fc_result), .fc_done(fc_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Modes: 0 ones, 1 single pixel, 2 max pixel / min weight, 3 y-ramp pixels with class*y weights.
    function automatic logic [15:0] rom_word(input int mode, input int a);
        case (mode)
            1:       return (a % 1152 == 0) ? 16'hFFFD : 16'd7;
            2:       return 16'h8000;
            3:       return 16'((a / 1152 + 1) * (a % 12 + 1));
            default: return 16'd1;
        endcase
    endfunction

    always @(posedge clk) if (weight_rd_en) weight_data <= rom_word(rom_mode, int'(weight_addr));

    function automatic logic [68:0] pix(input int mode, input int m, input int x, input int y);
        case (mode)
            0:       return 69'd1;
            1:       return (m == 0 && x == 0 && y == 0) ? 69'd5 : 69'd0;
            2:       return {69{1'b1}};
            3:       return 69'(y + 1);
            default: return 69'd0;
        endcase
    endfunction

    function automatic logic signed [97:0] exp_val(input int mode, input int c);
        logic signed [97:0] mx;
        mx = (98'sd1 <<< 69) - 98'sd1;
        case (mode)
            0:       return 98'sd1152;
            1:       return -98'sd15;
            2:       return -(98'sd37748736 * mx);
            default: return 98'(62400 * (c + 1));
        endcase
    endfunction

    task automatic check(input string name, input logic signed [127:0] act, input logic signed [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_pool(input int mode);
        for (int x = 0; x < 12; x++) begin
            for (int y = 0; y < 12; y++) begin
                p1[x][y] = pix(mode, 0, x, y);
                p2[x][y] = pix(mode, 1, x, y);
                p3[x][y] = pix(mode, 2, x, y);
                p4[x][y] = pix(mode, 3, x, y);
                p5[x][y] = pix(mode, 4, x, y);
                p6[x][y] = pix(mode, 5, x, y);
                p7[x][y] = pix(mode, 6, x, y);
                p8[x][y] = pix(mode, 7, x, y);
            end
        end
    endtask

    task automatic push_exp(input int e0, input int mode);
        exp_t e;
        e.done_cyc = 32'(e0 + RUN_LEN);
        for (int c = 0; c < 10; c++) e.res[c] = exp_val(mode, c);
        sb.push_back(e);
    endtask

    task automatic start_run(input int mode, output int e0);
        @(negedge clk);
        set_pool(mode);
        rom_mode  = mode;
        fc_enable = 1'b1;
        pool_done = 1'b1;
        e0 = cyc + 1;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!fc_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_within_budget", fc_done, 1);
    endtask

    task automatic end_run();
        fc_enable = 1'b0;
        @(negedge clk);
        check("done_cleared_on_release", fc_done, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fc_done"}, fc_done, 0);
        check({tag, "_rd_en"}, weight_rd_en, 0);
        check({tag, "_addr"}, weight_addr, 0);
        for (int c = 0; c < 10; c++) check($sformatf("%s_fc_result[%0d]", tag, c), fc_result[c], 0);
    endtask

    always @(negedge clk) begin
        if (fc_done && !done_prev) begin
            if (sb.size() == 0) begin
                check("done_without_request", fc_done, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_cycle", cyc, e.done_cyc);
                for (int c = 0; c < 10; c++)
                    check($sformatf("fc_result[%0d]", c), fc_result[c], $signed(e.res[c]));
            end
        end
        done_prev = fc_done;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        logic ok;
        rst = 1'b1;
        fc_enable = 1'b0;
        pool_done = 1'b0;
        set_pool(4);
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        fc_enable = 1'b1;
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (weight_rd_en || fc_done) ok = 1'b0;
        end
        check("idle_hold_without_pool_done", ok, 1);
        fc_enable = 1'b0;

        start_run(0, e0);
        push_exp(e0, 0);
        @(negedge clk);
        pool_done = 1'b0;
        check("first_rd_en", weight_rd_en, 1);
        check("first_addr", weight_addr, 0);
        @(negedge clk);
        check("second_addr", weight_addr, 1);
        while (cyc < e0 + 11519) @(negedge clk);
        check("last_addr", weight_addr, 11519);
        check("last_rd_en", weight_rd_en, 1);
        @(negedge clk);
        check("drain_rd_en", weight_rd_en, 0);
        check("drain_addr", weight_addr, 0);
        wait_done(10);
        end_run();

        start_run(1, e0);
        push_exp(e0, 1);
        @(negedge clk);
        pool_done = 1'b0;
        wait_done(11600);
        end_run();

        start_run(2, e0);
        push_exp(e0, 2);
        @(negedge clk);
        pool_done = 1'b0;
        wait_done(11600);
        ok = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (weight_rd_en || !fc_done) ok = 1'b0;
        end
        check("done_hold_no_restart", ok, 1);
        end_run();
        for (int c = 0; c < 10; c++)
            check($sformatf("retained_fc_result[%0d]", c), fc_result[c], exp_val(2, c));

        start_run(0, e0);
        @(negedge clk);
        pool_done = 1'b0;
        while (cyc < e0 + 4999) @(negedge clk);
        fc_enable = 1'b0;
        @(negedge clk);
        check_all_zero("abort");
        @(negedge clk);
        check("abort_stays_idle", weight_rd_en, 0);

        start_run(3, e0);
        push_exp(e0, 3);
        @(negedge clk);
        pool_done = 1'b0;
        set_pool(4);
        wait_done(11600);
        end_run();

        start_run(0, e0);
        @(negedge clk);
        pool_done = 1'b0;
        while (cyc < e0 + 99) @(negedge clk);
        rst = 1'b1;
        fc_enable = 1'b0;
        @(negedge clk);
        check_all_zero("midrun_reset");
        rst = 1'b0;
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (weight_rd_en || fc_done) ok = 1'b0;
        end
        check("post_reset_idle", ok, 1);

        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
